ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 8, system bus and data word width.
REQ-002 SHALL have parameter OP_W, default 3, opcode field width; address width AW = WORD_W-OP_W.
REQ-003 SHALL have one clock and a synchronous, active-high reset, ports clock and reset; all state changes on posedge clock only.
REQ-004 Ports, in order (name direction width meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req  in  2  per-requester access request (bit 0 = CPU, bit 1 = IO/DMA)
- we  in  2  per-requester write enable (1 write, 0 read)
- addr0, addr1  in  AW  requester addresses
- wdata0, wdata1  in  WORD_W  requester write data
- ack  out  2  one-cycle completion pulse per requester
- rdata  out  WORD_W  read data, shared by both requesters
- grant  out  1  index of the requester being served
- busy  out  1  high in any state other than IDLE
- load_MAR, load_MDR, CS, R_NW, MDR_bus  out  1  RAM control strobes
- sysbus  inout  WORD_W  shared tristate system bus

Function
REQ-005 FSM states SHALL be IDLE, ADDR, WDATA, ACCESS, RDATA, DONE.
REQ-006 In IDLE with any req bit high, the block SHALL grant one requester, latch its we/addr/wdata into internal registers and move to ADDR; with req == 0 it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be 2-way round-robin: a single request is granted directly; with both bits high, the requester not granted last SHALL win.
REQ-008 ADDR SHALL drive the latched address, zero-extended to WORD_W, on sysbus, assert load_MAR, then go to WDATA if write, else ACCESS.
REQ-009 WDATA SHALL drive the latched wdata on sysbus, assert load_MDR, then go to ACCESS.
REQ-010 ACCESS SHALL assert CS with R_NW = ~we_latched, then go to RDATA if read, else DONE.
REQ-011 RDATA SHALL assert MDR_bus, leave sysbus undriven, capture sysbus into rdata at the end of the cycle, then go to DONE.
REQ-012 DONE SHALL pulse ack[grant] for exactly one cycle, then go to IDLE; rdata SHALL hold until the next read capture.
REQ-013 Latency from the IDLE grant cycle to ack SHALL be 4 cycles for both write and read; the minimum back-to-back period SHALL be 5 cycles, including one IDLE cycle.
REQ-014 sysbus SHALL be driven only in ADDR and WDATA and SHALL be high-impedance in all other states.
REQ-015 At most one of load_MAR, load_MDR, CS and MDR_bus SHALL be high in any cycle; R_NW SHALL be 1 whenever CS is low.
REQ-016 Changes on req, we, addr or wdata after the grant SHALL NOT affect the transaction in flight; a dropped req SHALL still complete and receive ack.
REQ-017 Handshake: a requester SHALL deassert req on the edge at which it samples ack; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-018 The block SHALL NOT range-check the address; out-of-window addresses SHALL complete with the full strobe sequence, and rdata then holds the undriven sysbus value.
REQ-019 grant SHALL be stable from ADDR through DONE.

Reset
REQ-020 Reset SHALL force state = IDLE, ack = 0, rdata = 0, grant = 0, busy = 0, all RAM strobes 0 except R_NW = 1, and sysbus high-impedance.
REQ-021 Reset SHALL set the last-granted pointer to 1, so requester 0 wins the first contention.
REQ-022 Reset asserted mid-transaction SHALL abort the transaction without an ack; no strobe SHALL be asserted in the cycle after reset.

Structure
REQ-023 A shared package ram_arb_pkg SHALL hold the state enum type and the default WORD_W/OP_W constants.
REQ-024 Round-robin selection SHALL be a sub-module rr_arbiter2 with inputs req[1:0] and last, outputs gnt_valid and gnt_idx.

Verification
REQ-025 Write: req = 01, we = 01, addr0 = 24, wdata0 = 8'hA5 -> load_MAR in cycle 1 with sysbus = 8'h18, load_MDR in cycle 2 with sysbus = 8'hA5, CS with R_NW = 0 in cycle 3, ack = 01 in cycle 4.
REQ-026 Read-back: after REQ-025, req = 01, we = 00, addr0 = 24 -> CS with R_NW = 1, then MDR_bus, then ack = 01 with rdata = 8'hA5.
REQ-027 Contention: req = 11 held from reset -> grants 0, 1, 0, 1 on successive transactions, each ack one-hot and matching grant.
REQ-028 Mid-flight change: requester 1 write to addr1 = 25, then addr1/wdata1 changed and req dropped in ADDR -> original address and data used, ack = 10 still issued.
REQ-029 Reset in ACCESS: reset for 1 cycle -> no ack, IDLE, strobes 0, R_NW = 1, sysbus Z the following cycle.
REQ-030 Bus discipline checker on all tests: sysbus driven only in ADDR/WDATA and strobes mutually exclusive in every cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter.
// Holds the default bus/opcode widths and the controller state encoding.
package ram_arb_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned OP_W_DEF   = 3;

  // Controller states. IDLE is all-zero so a cleared register means idle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_ACCESS = 3'd3,
    S_RDATA  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector.
// Ports:
//   req[1:0]  - request bits (0 = CPU, 1 = IO/DMA)
//   last      - index granted most recently
//   gnt_valid - at least one request present
//   gnt_idx   - index of the winning requester
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // A lone request wins outright; on contention the one not served last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM access controller sequencing MAR/MDR/RAM strobes over a
// shared tristate system bus.
// Ports:
//   clock, reset     - clock and synchronous active-high reset
//   req, we          - per-requester request and write enable
//   addr0/1, wdata0/1- per-requester address and write data
//   ack              - one-cycle completion pulse per requester
//   rdata            - read data captured from sysbus, held until next read
//   grant            - index of the requester being served
//   busy             - controller not idle
//   load_MAR, load_MDR, CS, R_NW, MDR_bus - RAM control strobes
//   sysbus           - shared tristate bus, driven only in ADDR and WDATA
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [1:0]               we,
  input  logic [WORD_W-OP_W-1:0]   addr0,
  input  logic [WORD_W-OP_W-1:0]   addr1,
  input  logic [WORD_W-1:0]        wdata0,
  input  logic [WORD_W-1:0]        wdata1,
  output logic [1:0]               ack,
  output logic [WORD_W-1:0]        rdata,
  output logic                     grant,
  output logic                     busy,
  output logic                     load_MAR,
  output logic                     load_MDR,
  output logic                     CS,
  output logic                     R_NW,
  output logic                     MDR_bus,
  inout  wire  [WORD_W-1:0]        sysbus
);

  localparam int unsigned AW = WORD_W - OP_W;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              lat_we_q, lat_we_d;
  logic [AW-1:0]     lat_addr_q, lat_addr_d;
  logic [WORD_W-1:0] lat_wdata_q, lat_wdata_d;

  logic [1:0]        ack_q, ack_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              load_mar_q, load_mar_d;
  logic              load_mdr_q, load_mdr_d;
  logic              cs_q, cs_d;
  logic              r_nw_q, r_nw_d;
  logic              mdr_bus_q, mdr_bus_d;
  logic              bus_oe_q, bus_oe_d;
  logic [WORD_W-1:0] bus_out_q, bus_out_d;

  logic              gnt_valid;
  logic              gnt_idx;

  rr_arbiter2 u_rr (
    .req       (req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state, request capture and registered-output decode.
  // Outputs are decoded from the next state so they align with state_q.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          state_d     = S_ADDR;
          grant_d     = gnt_idx;
          last_d      = gnt_idx;
          lat_we_d    = gnt_idx ? we[1]  : we[0];
          lat_addr_d  = gnt_idx ? addr1  : addr0;
          lat_wdata_d = gnt_idx ? wdata1 : wdata0;
        end
      end
      S_ADDR:   state_d = lat_we_q ? S_WDATA : S_ACCESS;
      S_WDATA:  state_d = S_ACCESS;
      S_ACCESS: state_d = lat_we_q ? S_DONE : S_RDATA;
      S_RDATA:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    load_mar_d = (state_d == S_ADDR);
    load_mdr_d = (state_d == S_WDATA);
    cs_d       = (state_d == S_ACCESS);
    mdr_bus_d  = (state_d == S_RDATA);
    // R_NW idles high; only a write access pulls it low.
    r_nw_d     = ~(cs_d & lat_we_d);

    bus_oe_d  = load_mar_d | load_mdr_d;
    bus_out_d = '0;
    if (load_mar_d) begin
      bus_out_d = {{OP_W{1'b0}}, lat_addr_d};
    end else if (load_mdr_d) begin
      bus_out_d = lat_wdata_d;
    end

    ack_d = 2'b00;
    if (state_d == S_DONE) begin
      ack_d = grant_d ? 2'b10 : 2'b01;
    end

    // RAM drives the bus during RDATA; sample it at the closing edge.
    rdata_d = (state_q == S_RDATA) ? sysbus : rdata_q;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      ack_q       <= 2'b00;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      load_mar_q  <= 1'b0;
      load_mdr_q  <= 1'b0;
      cs_q        <= 1'b0;
      r_nw_q      <= 1'b1;
      mdr_bus_q   <= 1'b0;
      bus_oe_q    <= 1'b0;
      bus_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      load_mar_q  <= load_mar_d;
      load_mdr_q  <= load_mdr_d;
      cs_q        <= cs_d;
      r_nw_q      <= r_nw_d;
      mdr_bus_q   <= mdr_bus_d;
      bus_oe_q    <= bus_oe_d;
      bus_out_q   <= bus_out_d;
    end
  end

  assign sysbus   = bus_oe_q ? bus_out_q : {WORD_W{1'bz}};
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign load_MAR = load_mar_q;
  assign load_MDR = load_mdr_q;
  assign CS       = cs_q;
  assign R_NW     = r_nw_q;
  assign MDR_bus  = mdr_bus_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected strobe phases
// and acks; a monitor pops and compares whenever the DUT shows a strobe/ack.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req, we;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  wire  [1:0] ack;
  wire  [7:0] rdata;
  wire        grant, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus;
  wire  [7:0] sysbus;

  ram_arbiter #(.WORD_W(8), .OP_W(3)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
    .load_MAR(load_MAR), .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW),
    .MDR_bus(MDR_bus), .sysbus(sysbus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Simple RAM behind MAR/MDR.
  logic [7:0] mem [0:31];
  logic [7:0] mar, mdr;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mar = 8'h00;
    mdr = 8'h00;
  end
  always @(posedge clock) begin
    if (load_MAR) mar <= sysbus;
    if (load_MDR) mdr <= sysbus;
    if (CS && !R_NW) mem[mar[4:0]] <= mdr;
    if (CS && R_NW) mdr <= mem[mar[4:0]];
  end
  assign sysbus = MDR_bus ? mdr : 8'bz;

  typedef struct { int kind; int cyc; logic [7:0] val; } strobe_t;
  typedef struct { int cyc; logic [1:0] ack; logic grant; logic [7:0] rdata; } ackexp_t;
  strobe_t sq[$];
  ackexp_t aq[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // kind: 0 load_MAR (val = sysbus), 1 load_MDR (sysbus), 2 CS (R_NW), 3 MDR_bus (sysbus)
  task automatic push_txn(input int k, input bit idx, input bit wr, input logic [7:0] mar_val,
                          input logic [7:0] d, input logic [7:0] exp_rd);
    sq.push_back(strobe_t'{kind: 0, cyc: k + 1, val: mar_val});
    if (wr) begin
      sq.push_back(strobe_t'{kind: 1, cyc: k + 2, val: d});
      sq.push_back(strobe_t'{kind: 2, cyc: k + 3, val: 8'h00});
    end else begin
      sq.push_back(strobe_t'{kind: 2, cyc: k + 2, val: 8'h01});
      sq.push_back(strobe_t'{kind: 3, cyc: k + 3, val: d});
    end
    aq.push_back(ackexp_t'{cyc: k + 4, ack: idx ? 2'b10 : 2'b01, grant: idx, rdata: exp_rd});
  endtask

  // Single transaction issued in an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_txn(input bit idx, input bit wr, input logic [4:0] a, input logic [7:0] mar_val,
                        input logic [7:0] d, input logic [7:0] exp_rd, input bit scramble);
    int k;
    k = cyc;
    check("busy_before_grant", int'(busy), 0);
    push_txn(k, idx, wr, mar_val, d, exp_rd);
    if (idx) begin
      req = 2'b10; we[1] = wr; addr1 = a; wdata1 = d;
    end else begin
      req = 2'b01; we[0] = wr; addr0 = a; wdata0 = d;
    end
    @(negedge clock);
    req = 2'b00;
    if (scramble) begin
      we = ~we;
      addr0 = 5'd7; addr1 = 5'd7;
      wdata0 = 8'hFF; wdata1 = 8'hFF;
    end
    check("busy_in_flight", int'(busy), 1);
    while (cyc < k + 5) @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"}, int'(ack), 0);
    check({tag, "_rdata"}, int'(rdata), 0);
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_strobes"}, int'({load_MAR, load_MDR, CS, MDR_bus}), 0);
    check({tag, "_rnw"}, int'(R_NW), 1);
  endtask

  // Monitor: bus discipline every cycle, scoreboard pops on strobe/ack.
  always @(negedge clock) begin
    if (mon_en) begin
      int n;
      int kind;
      logic [7:0] got_val;
      n = int'(load_MAR) + int'(load_MDR) + int'(CS) + int'(MDR_bus);
      check("strobe_exclusive", (n > 1) ? 1 : 0, 0);
      check("rnw_high_when_idle", (!CS && !R_NW) ? 1 : 0, 0);
      if (n == 1) begin
        kind = load_MAR ? 0 : load_MDR ? 1 : CS ? 2 : 3;
        got_val = (kind == 2) ? {7'b0, R_NW} : sysbus;
        if (sq.size() == 0) begin
          check("unexpected_strobe_kind", kind, -1);
        end else begin
          strobe_t e;
          e = sq.pop_front();
          check("strobe_kind", kind, e.kind);
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_value", int'(got_val), int'(e.val));
        end
      end
      if (ack != 2'b00) begin
        if (aq.size() == 0) begin
          check("unexpected_ack", int'(ack), 0);
        end else begin
          ackexp_t a;
          a = aq.pop_front();
          check("ack_value", int'(ack), int'(a.ack));
          check("ack_cycle", cyc, a.cyc);
          check("ack_grant", int'(grant), int'(a.grant));
          check("ack_rdata", int'(rdata), int'(a.rdata));
        end
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 5'd0; addr1 = 5'd0; wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;
    check_reset_state("reset");

    // Contention from reset: 0,1,0,1, all writes.
    k = cyc;
    req = 2'b11; we = 2'b11;
    addr0 = 5'd3; wdata0 = 8'h11;
    addr1 = 5'd4; wdata1 = 8'h22;
    push_txn(k,      1'b0, 1'b1, 8'h03, 8'h11, 8'h00);
    push_txn(k + 5,  1'b1, 1'b1, 8'h04, 8'h22, 8'h00);
    push_txn(k + 10, 1'b0, 1'b1, 8'h03, 8'h11, 8'h00);
    push_txn(k + 15, 1'b1, 1'b1, 8'h04, 8'h22, 8'h00);
    while (cyc < k + 19) @(negedge clock);
    req = 2'b00;
    while (cyc < k + 20) @(negedge clock);

    // Write A5 to 24, then read it back.
    do_txn(1'b0, 1'b1, 5'd24, 8'h18, 8'hA5, 8'h00, 1'b0);
    do_txn(1'b0, 1'b0, 5'd24, 8'h18, 8'hA5, 8'hA5, 1'b0);

    // Requester 1 write with inputs changed and req dropped during ADDR.
    do_txn(1'b1, 1'b1, 5'd25, 8'h19, 8'h5C, 8'hA5, 1'b1);
    do_txn(1'b1, 1'b0, 5'd25, 8'h19, 8'h5C, 8'h5C, 1'b0);
    do_txn(1'b0, 1'b0, 5'd7,  8'h07, 8'h00, 8'h00, 1'b0);
    do_txn(1'b0, 1'b0, 5'd3,  8'h03, 8'h11, 8'h11, 1'b0);
    do_txn(1'b1, 1'b0, 5'd4,  8'h04, 8'h22, 8'h22, 1'b0);

    // Reset during ACCESS of a requester-1 read: aborted, no ack.
    k = cyc;
    sq.push_back(strobe_t'{kind: 0, cyc: k + 1, val: 8'h19});
    sq.push_back(strobe_t'{kind: 2, cyc: k + 2, val: 8'h01});
    req = 2'b10; we = 2'b00; addr1 = 5'd25;
    @(negedge clock);
    req = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("abort");
    repeat (8) @(negedge clock);

    // Recovery after abort.
    do_txn(1'b1, 1'b1, 5'd9, 8'h09, 8'h3C, 8'h00, 1'b0);
    do_txn(1'b0, 1'b0, 5'd9, 8'h09, 8'h3C, 8'h3C, 1'b0);

    for (int i = 0; i < 50 && (sq.size() != 0 || aq.size() != 0); i++) @(negedge clock);
    check("strobe_queue_drained", sq.size(), 0);
    check("ack_queue_drained", aq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
